if_fetch_unit: RTL

Instruction-fetch front end of the LC-3b pipeline and the producer side of the IF/ID stage register.
- Holds the PC and issues read requests to the instruction memory port.
- Presents pc_plus2 and instruction together with load and flush strobes for the IF/ID register.
- Honours downstream stalls and branch redirects, including a redirect that arrives while a memory read is outstanding.

---
 rtl/if_fetch_unit_pkg.sv | 26 ++
 rtl/if_fetch_unit_pc_reg.sv | 54 +++++
 rtl/if_fetch_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_pkg.sv
// ============================================================================
// Module : if_fetch_unit_pkg
// Brief  : Shared types for the LC-3b instruction-fetch front end.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package if_fetch_unit_pkg;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } lc3b_fetch_state;

    // Next-PC source selected by the fetch FSM
    localparam logic [1:0] PC_KEEP  = 2'd0;
    localparam logic [1:0] PC_INC   = 2'd1;
    localparam logic [1:0] PC_REDIR = 2'd2;
    localparam logic [1:0] PC_PEND  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/if_fetch_unit_pc_reg.sv
// ============================================================================
// Module : if_fetch_unit_pc_reg
// Brief  : PC / pending-redirect register pair with next-PC select.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_fetch_unit_pc_reg
    import if_fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  pc_sel_i,
    input  logic        pend_load_i,
    input  logic [15:0] redirect_pc_i,
    output logic [15:0] pc_o,
    output logic [15:0] pc_plus2_o
);

    lc3b_word pc_q, pc_d;
    lc3b_word pending_q, pending_d;
    lc3b_word pc_plus2_w;

    assign pc_plus2_w = pc_q + 16'd2;

    always_comb begin
        pc_d = pc_q;
        case (pc_sel_i)
            PC_INC:   pc_d = pc_plus2_w;
            PC_REDIR: pc_d = redirect_pc_i;
            PC_PEND:  pc_d = pending_q;
            default:  pc_d = pc_q;
        endcase
        pending_d = pend_load_i ? redirect_pc_i : pending_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q      <= RESET_PC;
            pending_q <= 16'h0000;
        end else begin
            pc_q      <= pc_d;
            pending_q <= pending_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus2_o = pc_plus2_w;

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
// Module : if_fetch_unit
// Brief  : LC-3b fetch stage; drives imem requests and the IF/ID load/flush.
//          Optional IF_FETCH_PERF_EN adds saturating fetch/bubble counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic        imem_resp,
    input  logic [15:0] imem_rdata,
    input  logic        ifid_stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        fetch_valid,
    output logic [15:0] pc_plus2,
    output logic [15:0] instruction,
    output logic        ifid_load,
    output logic        ifid_flush
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_bubbles
`endif
);

    lc3b_fetch_state state_q, state_d;
    lc3b_word        inst_buf_q, inst_buf_d;
    logic [1:0]      pc_sel_w;
    logic            pend_load_w;
    logic            accept_w;
    lc3b_word        pc_w;

    if_fetch_unit_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .reset_n       (reset_n),
        .pc_sel_i      (pc_sel_w),
        .pend_load_i   (pend_load_w),
        .redirect_pc_i (redirect_pc),
        .pc_o          (pc_w),
        .pc_plus2_o    (pc_plus2)
    );

    assign imem_read    = reset_n & (state_q != HOLD);
    assign imem_address = pc_w;
    assign fetch_valid  = reset_n & ~redirect &
                          (((state_q == FETCH) & imem_resp) | (state_q == HOLD));
    assign instruction  = (state_q == HOLD) ? inst_buf_q : imem_rdata;
    assign accept_w     = fetch_valid & ~ifid_stall;
    assign ifid_load    = reset_n & (~ifid_stall | redirect);
    assign ifid_flush   = ifid_load & (redirect | ~fetch_valid);

    // Redirect outranks everything; in DROP the stale response only releases the FSM
    always_comb begin
        state_d     = state_q;
        inst_buf_d  = inst_buf_q;
        pc_sel_w    = PC_KEEP;
        pend_load_w = 1'b0;
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    if (imem_resp) begin
                        pc_sel_w = PC_REDIR;
                    end else begin
                        pend_load_w = 1'b1;
                        state_d     = DROP;
                    end
                end else if (imem_resp) begin
                    if (accept_w) begin
                        pc_sel_w = PC_INC;
                    end else begin
                        inst_buf_d = imem_rdata;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_sel_w = PC_REDIR;
                    state_d  = FETCH;
                end else if (!ifid_stall) begin
                    pc_sel_w = PC_INC;
                    state_d  = FETCH;
                end
            end
            DROP: begin
                if (imem_resp) begin
                    pc_sel_w = redirect ? PC_REDIR : PC_PEND;
                    state_d  = FETCH;
                end else if (redirect) begin
                    pend_load_w = 1'b1;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FETCH;
            inst_buf_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            inst_buf_q <= inst_buf_d;
        end
    end

    a_no_resp_in_hold : assert property (
        @(posedge clk) disable iff (!reset_n) !((state_q == HOLD) && imem_resp)
    );

`ifdef IF_FETCH_PERF_EN
    logic [15:0] fetched_q, bubbles_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetched_q <= 16'h0000;
            bubbles_q <= 16'h0000;
        end else begin
            if (accept_w && (fetched_q != 16'hFFFF))
                fetched_q <= fetched_q + 16'd1;
            if (ifid_load && ifid_flush && (bubbles_q != 16'hFFFF))
                bubbles_q <= bubbles_q + 16'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`endif

endmodule

`default_nettype wire
